// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - ROM/execute handshake bundle for the fetch sequencer
interface fetch_sequencer_if #(
   parameter int PC_WIDTH = 12
);
   logic                romReady;
   logic                jumpTaken;
   logic [PC_WIDTH-1:0] jumpTarget;
   logic                halt;
   logic                resume;
   logic [PC_WIDTH-1:0] pc;
   logic                romReq;
   logic                phase;
   logic                execEn;
   logic                halted;
   logic                fault;

   // Environment side: ROM, execute stage and run control.
   modport master (
      output romReady, jumpTaken, jumpTarget, halt, resume,
      input  pc, romReq, phase, execEn, halted, fault
   );

   // Sequencer side.
   modport slave (
      input  romReady, jumpTaken, jumpTarget, halt, resume,
      output pc, romReq, phase, execEn, halted, fault
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and fetch/execute phase controller
module fetch_sequencer #(
   parameter int PC_WIDTH = 12,
   parameter int TIMEOUT  = 15
) (
   input  logic            clk,
   input  logic            notReset,
   fetch_sequencer_if.slave bus
);

   // Wait counter is at least one bit wide so TIMEOUT=0 still elaborates.
   localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [WCW-1:0] WAIT_MAX  = {WCW{1'b1}};

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC   = 2'd1,
      S_HALTED = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [WCW-1:0]      wait_q, wait_d;

   // State, PC and wait counter; reset drops any in-flight instruction.
   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wait_q  <= wait_d;
      end
   end

   // Next state: ROM handshake in FETCH, PC update on the edge closing EXEC.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wait_d  = wait_q;
      case (state_q)
         S_FETCH: begin
            if (bus.romReady) begin
               state_d = S_EXEC;
               wait_d  = '0;
            end else begin
               // Saturate so a disabled timeout cannot wrap the counter.
               if (wait_q != WAIT_MAX) begin
                  wait_d = wait_q + 1'b1;
               end
               // wait_q counts earlier unready cycles, so this is the TIMEOUT-th.
               if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                  state_d = S_FAULT;
               end
            end
         end
         S_EXEC: begin
            pc_d    = bus.jumpTaken ? bus.jumpTarget : pc_q + 1'b1;
            state_d = bus.halt ? S_HALTED : S_FETCH;
            wait_d  = '0;
         end
         S_HALTED: begin
            if (bus.resume) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Strobes decoded from the current state; phase also needs romReady.
   always_comb begin
      bus.romReq = (state_q == S_FETCH);
      bus.phase  = (state_q == S_FETCH) && bus.romReady;
      bus.execEn = (state_q == S_EXEC);
      bus.halted = (state_q == S_HALTED);
      bus.fault  = (state_q == S_FAULT);
   end

   assign bus.pc = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
   localparam int PW = 12;

   localparam int M_FETCH  = 0;
   localparam int M_EXEC   = 1;
   localparam int M_HALTED = 2;
   localparam int M_FAULT  = 3;

   logic          clk = 1'b0;
   logic          notReset = 1'b0;
   logic          romReady = 1'b1;
   logic          jumpTaken = 1'b0;
   logic [PW-1:0] jumpTarget = '0;
   logic          halt = 1'b0;
   logic          resume = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_sequencer_if #(.PC_WIDTH(PW)) bus0 ();
   fetch_sequencer_if #(.PC_WIDTH(PW)) bus1 ();

   assign bus0.romReady   = romReady;
   assign bus0.jumpTaken  = jumpTaken;
   assign bus0.jumpTarget = jumpTarget;
   assign bus0.halt       = halt;
   assign bus0.resume     = resume;
   assign bus1.romReady   = romReady;
   assign bus1.jumpTaken  = jumpTaken;
   assign bus1.jumpTarget = jumpTarget;
   assign bus1.halt       = halt;
   assign bus1.resume     = resume;

   fetch_sequencer #(.PC_WIDTH(PW), .TIMEOUT(15)) dut0 (
      .clk(clk), .notReset(notReset), .bus(bus0.slave)
   );
   fetch_sequencer #(.PC_WIDTH(PW), .TIMEOUT(4)) dut1 (
      .clk(clk), .notReset(notReset), .bus(bus1.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one entry per DUT, plain integers for pc and wait count.
   int m_pc[2]   = '{0, 0};
   int m_mode[2] = '{M_FETCH, M_FETCH};
   int m_wait[2] = '{0, 0};
   int tmo[2]    = '{15, 4};

   always @(posedge clk or negedge notReset) begin
      for (int k = 0; k < 2; k++) begin
         if (!notReset) begin
            m_pc[k] = 0; m_mode[k] = M_FETCH; m_wait[k] = 0;
         end else begin
            case (m_mode[k])
               M_FETCH: begin
                  if (romReady) begin
                     m_mode[k] = M_EXEC; m_wait[k] = 0;
                  end else begin
                     m_wait[k] = m_wait[k] + 1;
                     if (tmo[k] != 0 && m_wait[k] == tmo[k]) m_mode[k] = M_FAULT;
                  end
               end
               M_EXEC: begin
                  m_pc[k]   = jumpTaken ? int'(jumpTarget) : (m_pc[k] + 1) % (1 << PW);
                  m_mode[k] = halt ? M_HALTED : M_FETCH;
                  m_wait[k] = 0;
               end
               M_HALTED: begin
                  if (resume) begin m_mode[k] = M_FETCH; m_wait[k] = 0; end
               end
               default: ;
            endcase
         end
      end
   end

   // Compare every cycle on the falling edge, away from state updates.
   always @(negedge clk) begin
      chk("d0_pc",     32'(bus0.pc),     32'(m_pc[0]));
      chk("d0_romReq", 32'(bus0.romReq), 32'(m_mode[0] == M_FETCH));
      chk("d0_phase",  32'(bus0.phase),  32'(m_mode[0] == M_FETCH && romReady));
      chk("d0_execEn", 32'(bus0.execEn), 32'(m_mode[0] == M_EXEC));
      chk("d0_halted", 32'(bus0.halted), 32'(m_mode[0] == M_HALTED));
      chk("d0_fault",  32'(bus0.fault),  32'(m_mode[0] == M_FAULT));
      chk("d1_pc",     32'(bus1.pc),     32'(m_pc[1]));
      chk("d1_romReq", 32'(bus1.romReq), 32'(m_mode[1] == M_FETCH));
      chk("d1_phase",  32'(bus1.phase),  32'(m_mode[1] == M_FETCH && romReady));
      chk("d1_execEn", 32'(bus1.execEn), 32'(m_mode[1] == M_EXEC));
      chk("d1_halted", 32'(bus1.halted), 32'(m_mode[1] == M_HALTED));
      chk("d1_fault",  32'(bus1.fault),  32'(m_mode[1] == M_FAULT));
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   int exp_pc[6]    = '{0, 0, 1, 1, 2, 2};
   int exp_phase[6] = '{1, 0, 1, 0, 1, 0};
   int exp_exec[6]  = '{0, 1, 0, 1, 0, 1};
   int stall = 0;

   initial begin
      #2;
      chk("rst_pc", 32'(bus0.pc), 32'h0);
      chk("rst_romReq", 32'(bus0.romReq), 32'h1);
      chk("rst_phase", 32'(bus0.phase), 32'h1);
      chk("rst_execEn", 32'(bus0.execEn), 32'h0);
      chk("rst_fault", 32'(bus0.fault), 32'h0);
      repeat (2) @(posedge clk);
      #1 notReset = 1'b1;
      #1;
      // Zero-wait alternation from reset.
      for (int i = 0; i < 6; i++) begin
         chk("seq_pc", 32'(bus0.pc), 32'(exp_pc[i]));
         chk("seq_phase", 32'(bus0.phase), 32'(exp_phase[i]));
         chk("seq_execEn", 32'(bus0.execEn), 32'(exp_exec[i]));
         nxt(); #1;
      end
      repeat (4) nxt();
      #1 chk("pre_jump_pc", 32'(bus0.pc), 32'h005);
      nxt(); jumpTaken = 1'b1; jumpTarget = 12'h3A0;
      #1 chk("jump_exec", 32'(bus0.execEn), 32'h1);
      nxt(); jumpTaken = 1'b0;
      #1 chk("jump_pc", 32'(bus0.pc), 32'h3A0);
      nxt(); jumpTaken = 1'b1; jumpTarget = 12'hFFF;
      nxt(); jumpTaken = 1'b0;
      #1 chk("top_pc", 32'(bus0.pc), 32'hFFF);
      nxt(); nxt();
      #1 chk("wrap_pc", 32'(bus0.pc), 32'h000);
      // Three wait states then ready.
      for (int i = 0; i < 4; i++) begin
         romReady = (i == 3);
         #1;
         chk("wait_romReq", 32'(bus0.romReq), 32'h1);
         chk("wait_phase", 32'(bus0.phase), 32'(i == 3));
         chk("wait_fault", 32'(bus1.fault), 32'h0);
         nxt();
      end
      nxt(); romReady = 1'b0;
      // TIMEOUT=4 instance faults after four unready cycles.
      for (int i = 0; i < 4; i++) begin
         #1 chk("tmo4_prefault", 32'(bus1.fault), 32'h0);
         nxt();
      end
      #1;
      chk("tmo4_fault", 32'(bus1.fault), 32'h1);
      chk("tmo4_pc", 32'(bus1.pc), 32'h001);
      chk("tmo4_romReq", 32'(bus1.romReq), 32'h0);
      chk("tmo15_nofault", 32'(bus0.fault), 32'h0);
      resume = 1'b1;
      nxt(); resume = 1'b0;
      #1 chk("tmo4_resume", 32'(bus1.fault), 32'h1);
      repeat (9) nxt();
      romReady = 1'b1;
      #1;
      chk("w14_phase", 32'(bus0.phase), 32'h1);
      chk("w14_fault", 32'(bus0.fault), 32'h0);
      nxt();
      #1 chk("w14_exec", 32'(bus0.execEn), 32'h1);
      nxt(); romReady = 1'b0;
      repeat (14) nxt();
      #1 chk("w15_prefault", 32'(bus0.fault), 32'h0);
      nxt();
      #1;
      chk("w15_fault", 32'(bus0.fault), 32'h1);
      chk("w15_pc", 32'(bus0.pc), 32'h002);
      #1 notReset = 1'b0;
      #1;
      chk("async_clr_fault", 32'(bus0.fault), 32'h0);
      chk("async_clr_pc", 32'(bus0.pc), 32'h0);
      nxt(); romReady = 1'b1; notReset = 1'b1;
      // Halt together with jump.
      nxt(); halt = 1'b1; jumpTaken = 1'b1; jumpTarget = 12'h010;
      nxt(); halt = 1'b0; jumpTaken = 1'b0;
      #1;
      chk("halt_halted", 32'(bus0.halted), 32'h1);
      chk("halt_pc", 32'(bus0.pc), 32'h010);
      chk("halt_romReq", 32'(bus0.romReq), 32'h0);
      chk("halt_phase", 32'(bus0.phase), 32'h0);
      nxt(); resume = 1'b1;
      nxt(); resume = 1'b0;
      #1;
      chk("resume_romReq", 32'(bus0.romReq), 32'h1);
      chk("resume_pc", 32'(bus0.pc), 32'h010);
      // Asynchronous reset in the middle of EXEC.
      nxt(); jumpTaken = 1'b1; jumpTarget = 12'h123;
      nxt(); jumpTaken = 1'b0;
      nxt();
      #1 chk("midexec_exec", 32'(bus0.execEn), 32'h1);
      chk("midexec_pc", 32'(bus0.pc), 32'h123);
      #2 notReset = 1'b0;
      #1;
      chk("async_pc", 32'(bus0.pc), 32'h0);
      chk("async_execEn", 32'(bus0.execEn), 32'h0);
      chk("async_romReq", 32'(bus0.romReq), 32'h1);
      nxt(); nxt(); notReset = 1'b1;
      #1 chk("restart_pc", 32'(bus0.pc), 32'h0);
      nxt();
      #1 chk("restart_exec_pc", 32'(bus0.pc), 32'h0);
      // Randomized traffic with stall bursts and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         nxt();
         if (stall == 0 && $urandom_range(0, 49) == 0) stall = $urandom_range(3, 17);
         if (stall > 0) begin
            romReady = 1'b0;
            stall--;
         end else begin
            romReady = ($urandom_range(0, 3) != 0);
         end
         jumpTaken  = $urandom_range(0, 2) == 0;
         jumpTarget = PW'($urandom);
         halt       = $urandom_range(0, 7) == 0;
         resume     = $urandom_range(0, 3) == 0;
         notReset   = !($urandom_range(0, 299) == 0);
      end
      nxt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
